// File: rtl/packConv.sv
// Shared types and constants for the 3x3 convolution window front end.
// Pixel data is opaque NBITS-wide words; a window is nine of them, index 3*dr+dc.
package packConv;

   localparam int NBITS     = 20;
   localparam int IMG_W_DEF = 32;
   localparam int IMG_H_DEF = 32;

   typedef logic [NBITS-1:0] regC;
   typedef regC [8:0] param9;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } conv_state_t;

   function automatic int win_idx(input int dr, input int dc);
      return 3 * dr + dc;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: synchronous write, read port returns the word at addr
// before this cycle's write lands, so a shared address gives read-before-write.
module line_buffer
   import packConv::*;
#(
   parameter int DEPTH = IMG_W_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  regC           wdata,
   output regC           rdata
);

   regC mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/conv_window3x3.sv
// Raster-order pixel stream to 3x3 sliding window with single-register backpressure.
// Define CONV_STRIDE2_EN to emit only windows at even (row-2, col-2) offsets.
module conv_window3x3
   import packConv::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  regC        pix_in,
   input  logic       in_valid,
   output logic       in_ready,
   output param9      window,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_done,
   output logic [1:0] fsm_state
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   // Handshakes: a word moves on the rising edge where valid && ready; valid never
   // waits on ready, and the producer holds its data stable until it is taken.
   logic          transfer;
   logic          emit;
   logic          col_last;
   logic          row_last;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   regC           lb1_rd;
   regC           lb2_rd;
   regC           col_new [3];
   regC           arr [3][3];
   conv_state_t   state;
   conv_state_t   state_nx;

   assign in_ready = !out_valid || out_ready;
   assign transfer = in_valid && in_ready;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

`ifdef CONV_STRIDE2_EN
   // Row and column offsets from 2 are even exactly when the counters are even.
   assign emit = transfer && (row >= RW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
`else
   assign emit = transfer && (row >= RW'(2)) && (col >= CW'(2));
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (transfer) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // lb1 holds row r-1, lb2 holds row r-2; the word leaving lb1 cascades into lb2.
   line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clock (clock),
      .we    (transfer),
      .addr  (col),
      .wdata (pix_in),
      .rdata (lb1_rd)
   );

   line_buffer #(.DEPTH(IMG_W)) u_lb2 (
      .clock (clock),
      .we    (transfer),
      .addr  (col),
      .wdata (lb1_rd),
      .rdata (lb2_rd)
   );

   always_comb begin
      col_new[0] = lb2_rd;
      col_new[1] = lb1_rd;
      col_new[2] = pix_in;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               arr[r][c] <= '0;
            end
         end
      end else if (transfer) begin
         for (int r = 0; r < 3; r++) begin
            arr[r][0] <= arr[r][1];
            arr[r][1] <= arr[r][2];
            arr[r][2] <= col_new[r];
         end
      end
   end

   // The window register is loaded with the post-shift array contents.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         window    <= '0;
      end else if (emit) begin
         out_valid <= 1'b1;
         for (int r = 0; r < 3; r++) begin
            window[win_idx(r, 0)] <= arr[r][1];
            window[win_idx(r, 1)] <= arr[r][2];
            window[win_idx(r, 2)] <= col_new[r];
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      frame_done = 1'b0;
      case (state)
         FILL: begin
            if (transfer && col_last && (row == RW'(1))) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (transfer && col_last && row_last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_nx   = FILL;
         end
         default: begin
            state_nx = FILL;
         end
      endcase
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_conv_window3x3.sv
// Scoreboard bench for conv_window3x3: DUT A runs directed frames, DUT B a 6x6 random-gap frame.
// Expected windows come from a frame-array reference model; a negedge monitor pops and compares.
module tb_conv_window3x3;
   import packConv::*;

`ifdef CONV_STRIDE2_EN
   localparam int WA = 5;
   localparam int HA = 5;
   localparam bit STRIDE2 = 1'b1;
`else
   localparam int WA = 4;
   localparam int HA = 4;
   localparam bit STRIDE2 = 1'b0;
`endif
   localparam int WB = 6;
   localparam int HB = 6;
   localparam int WV = 9 * NBITS;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             rst_n      [2];
   logic [NBITS-1:0] pix_in     [2];
   logic             in_valid   [2];
   logic             in_ready   [2];
   logic [WV-1:0]    window     [2];
   logic             out_valid  [2];
   logic             out_ready  [2];
   logic             frame_done [2];
   logic [1:0]       fsm_state  [2];

   conv_window3x3 #(.IMG_W(WA), .IMG_H(HA)) dut_a (
      .clock      (clock),
      .reset      (rst_n[0]),
      .pix_in     (pix_in[0]),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .window     (window[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .frame_done (frame_done[0]),
      .fsm_state  (fsm_state[0])
   );

   conv_window3x3 #(.IMG_W(WB), .IMG_H(HB)) dut_b (
      .clock      (clock),
      .reset      (rst_n[1]),
      .pix_in     (pix_in[1]),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .window     (window[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .frame_done (frame_done[1]),
      .fsm_state  (fsm_state[1])
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [WV-1:0] exp_q0 [$];
   logic [WV-1:0] exp_q1 [$];
   int            fd_q0  [$];
   int            fd_q1  [$];
   int            frm    [2][64];
   int            win_cnt   [2];
   int            fd_cnt    [2];
   logic [WV-1:0] first_win [2];
   logic [WV-1:0] last_win  [2];
   bit            rnd_on = 1'b0;

   task automatic chk(input string name, input logic [WV-1:0] act, input logic [WV-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int w_of(input int d);
      return (d == 0) ? WA : WB;
   endfunction

   function automatic int h_of(input int d);
      return (d == 0) ? HA : HB;
   endfunction

   function automatic int exp_cnt(input int d);
      if (STRIDE2) return ((w_of(d) - 1) / 2) * ((h_of(d) - 1) / 2);
      return (w_of(d) - 2) * (h_of(d) - 2);
   endfunction

   function automatic int last_tl(input int d, input int base);
      int w = w_of(d);
      int h = h_of(d);
      if (STRIDE2) return base + ((h - 3) / 2 * 2) * w + ((w - 3) / 2 * 2);
      return base + (h - 3) * w + (w - 3);
   endfunction

   // Window of a counting-pattern image whose top-left pixel is b.
   function automatic logic [WV-1:0] mk(input int b, input int w);
      logic [WV-1:0] v = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            v[(3*dr+dc)*NBITS +: NBITS] = NBITS'(b + dr * w + dc);
      return v;
   endfunction

   // Windows whose bottom-right pixel lies among the first n pixels of the frame.
   task automatic model_frame(input int d, input int n);
      int w = w_of(d);
      int h = h_of(d);
      logic [WV-1:0] v;
      for (int r = 2; r < h; r++) begin
         for (int c = 2; c < w; c++) begin
            if (STRIDE2 && (((r - 2) % 2) != 0 || ((c - 2) % 2) != 0)) continue;
            if (r * w + c >= n) continue;
            v = '0;
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  v[(3*dr+dc)*NBITS +: NBITS] = NBITS'(frm[d][(r - 2 + dr) * w + (c - 2 + dc)]);
            if (d == 0) exp_q0.push_back(v);
            else        exp_q1.push_back(v);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_px(input int d, input int p, input bit last);
      int t = 0;
      in_valid[d] = 1'b1;
      pix_in[d]   = NBITS'(p);
      forever begin
         @(negedge clock);
         if (in_ready[d]) break;
         t++;
         if (t > 500) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout dut=%0d actual=stalled required=accept", d);
            break;
         end
      end
      if (last) begin
         if (d == 0) fd_q0.push_back(cyc + 1);
         else        fd_q1.push_back(cyc + 1);
      end
      @(posedge clock);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic send_frame(input int d, input int base, input int n, input bit rnd_px, input int max_gap);
      int full = w_of(d) * h_of(d);
      for (int i = 0; i < n; i++)
         frm[d][i] = rnd_px ? int'($urandom_range(0, (1 << NBITS) - 1)) : base + i;
      model_frame(d, n);
      for (int i = 0; i < n; i++) begin
         if (max_gap > 0) idle($urandom_range(0, max_gap));
         send_px(d, frm[d][i], i == full - 1);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic drain(input int d);
      int t = 0;
      while (qsize(d) != 0 && t < 300) begin
         @(posedge clock);
         t++;
      end
      if (qsize(d) != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout dut=%0d actual=%0d pending required=0", d, qsize(d));
      end
      idle(3);
   endtask

   task automatic clear_stats(input int d);
      win_cnt[d] = 0;
      fd_cnt[d]  = 0;
   endtask

   task automatic check_reset_state(input int d);
      chk("rst_out_valid", WV'(out_valid[d]), '0);
      chk("rst_frame_done", WV'(frame_done[d]), '0);
      chk("rst_window", window[d], '0);
      chk("rst_fsm_fill", WV'(fsm_state[d]), WV'(FILL));
      chk("rst_in_ready", WV'(in_ready[d]), WV'(1));
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n[d] && out_valid[d] && out_ready[d]) begin
            logic [WV-1:0] exp_v;
            bit            have;
            have = (qsize(d) != 0);
            exp_v = '0;
            if (have) exp_v = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (!have) begin
               checks++;
               errors++;
               $display("FAIL window_unexpected dut=%0d actual=%h required=none", d, window[d]);
            end else begin
               chk(d == 0 ? "window_a" : "window_b", window[d], exp_v);
            end
            if (win_cnt[d] == 0) first_win[d] = window[d];
            last_win[d] = window[d];
            win_cnt[d]++;
         end
         if (rst_n[d] && frame_done[d]) begin
            int exp_c;
            bit have;
            have  = (d == 0) ? (fd_q0.size() != 0) : (fd_q1.size() != 0);
            exp_c = -1;
            if (have) exp_c = (d == 0) ? fd_q0.pop_front() : fd_q1.pop_front();
            chk("frame_done_cycle", WV'(cyc), WV'(exp_c));
            fd_cnt[d]++;
         end
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (rnd_on) out_ready[1] = ($urandom_range(0, 3) != 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [WV-1:0] held;
      for (int d = 0; d < 2; d++) begin
         rst_n[d]     = 1'b0;
         in_valid[d]  = 1'b0;
         pix_in[d]    = '0;
         out_ready[d] = 1'b1;
         clear_stats(d);
      end
      idle(3);
      @(negedge clock);
      check_reset_state(0);
      check_reset_state(1);
      @(posedge clock);
      #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      idle(2);

      // Counting frame with the sink always ready.
      clear_stats(0);
      send_frame(0, 0, WA * HA, 1'b0, 0);
      drain(0);
      chk("basic_count", WV'(win_cnt[0]), WV'(exp_cnt(0)));
      chk("basic_first", first_win[0], mk(0, WA));
      chk("basic_last", last_win[0], mk(last_tl(0, 0), WA));
      chk("basic_frame_done", WV'(fd_cnt[0]), WV'(1));

      // Stall the sink on the first window.
      clear_stats(0);
      out_ready[0] = 1'b0;
      fork
         send_frame(0, 50, WA * HA, 1'b0, 0);
         begin
            int t = 0;
            do begin
               @(negedge clock);
               t++;
            end while (!out_valid[0] && t < 500);
            chk("bp_first_seen", WV'(out_valid[0]), WV'(1));
            held = window[0];
            repeat (5) begin
               @(negedge clock);
               chk("bp_window_stable", window[0], held);
               chk("bp_out_valid", WV'(out_valid[0]), WV'(1));
               chk("bp_in_ready", WV'(in_ready[0]), '0);
            end
            @(posedge clock);
            #1;
            out_ready[0] = 1'b1;
         end
      join
      drain(0);
      chk("bp_count", WV'(win_cnt[0]), WV'(exp_cnt(0)));
      chk("bp_first", first_win[0], mk(50, WA));

      // Reset mid-frame, then a fresh frame must start at (0,0).
      clear_stats(0);
      send_frame(0, 0, 10, 1'b0, 0);
      idle(1);
      rst_n[0] = 1'b0;
      idle(1);
      @(negedge clock);
      check_reset_state(0);
      @(posedge clock);
      #1;
      rst_n[0] = 1'b1;
      idle(1);
      send_frame(0, 100, WA * HA, 1'b0, 0);
      drain(0);
      chk("rst_frame_count", WV'(win_cnt[0]), WV'(exp_cnt(0)));
      chk("rst_frame_first", first_win[0], mk(100, WA));

      // Two frames back to back with in_valid never dropping between pixels.
      clear_stats(0);
      send_frame(0, 200, WA * HA, 1'b0, 0);
      send_frame(0, 300, WA * HA, 1'b0, 0);
      drain(0);
      chk("b2b_count", WV'(win_cnt[0]), WV'(2 * exp_cnt(0)));
      chk("b2b_frame_done", WV'(fd_cnt[0]), WV'(2));
      chk("b2b_last", last_win[0], mk(last_tl(0, 300), WA));

      // 6x6 random pixels with random input gaps and sink stalls.
      clear_stats(1);
      rnd_on = 1'b1;
      send_frame(1, 0, WB * HB, 1'b1, 2);
      send_frame(1, 0, WB * HB, 1'b1, 1);
      rnd_on = 1'b0;
      out_ready[1] = 1'b1;
      drain(1);
      chk("rand_count", WV'(win_cnt[1]), WV'(2 * exp_cnt(1)));
      chk("rand_frame_done", WV'(fd_cnt[1]), WV'(2));

      idle(3);
      chk("exp_q_a_empty", WV'(exp_q0.size()), '0);
      chk("exp_q_b_empty", WV'(exp_q1.size()), '0);
      chk("fd_q_a_empty", WV'(fd_q0.size()), '0);
      chk("fd_q_b_empty", WV'(fd_q1.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_window3x3.md
CONV_WINDOW3X3 -- requirements
Module: conv_window3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning pixels per image row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 32, meaning rows per frame (legal range 3..1024).
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port pix_in  input  regC (NBITS=20)  meaning raster-order pixel.
REQ-006 SHALL have port in_valid  input  1  meaning pix_in is valid.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts pix_in this cycle.
REQ-008 SHALL have port window  output  param9  meaning the 3x3 window; index 3*dr+dc, where [0] is top-left (r-2,c-2) and [8] is bottom-right (r,c).
REQ-009 SHALL have port out_valid  output  1  meaning window is valid.
REQ-010 SHALL have port out_ready  input  1  meaning the downstream conv stage consumes window.
REQ-011 SHALL have port frame_done  output  1  meaning a one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL accept a pixel only when in_valid && in_ready, which is the transfer condition.
REQ-013 SHALL drive in_ready = !out_valid || out_ready, i.e. a single output register with pass-through backpressure.
REQ-014 SHALL keep col and row counters (0..IMG_W-1, 0..IMG_H-1) that advance on each transfer; col wraps to 0 and increments row; row wraps to 0 after the last pixel.
REQ-015 SHALL use two line buffers of IMG_W words holding rows r-1 and r-2, read and written at address col on each transfer.
REQ-016 SHALL shift a 3x3 register array left by one column on each transfer, loading the new column {linebuf2[col], linebuf1[col], pix_in}.
REQ-017 SHALL, on a transfer with row>=2 && col>=2, register window and set out_valid on the next edge (latency 1 cycle).
REQ-018 SHALL produce no window for col<2 (no horizontal wrap across rows) and no window for row<2; there is no padding.
REQ-019 SHALL clear out_valid on out_ready when no new window is produced in the same cycle; a simultaneous new window and consume keeps out_valid at 1 with new data.
REQ-020 SHALL hold window and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL implement an FSM with states FILL (row<2), RUN (row>=2) and DONE; FILL->RUN when row reaches 2; RUN->DONE on transfer of pixel (IMG_H-1, IMG_W-1); DONE->FILL unconditionally after one cycle.
REQ-022 SHALL assert frame_done for exactly the DONE cycle; in_ready follows REQ-013 in DONE, and a pixel accepted in DONE is pixel (0,0) of the next frame.
REQ-023 SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-024 SHALL treat pixel data as opaque (no arithmetic); all widths are NBITS.

Reset
REQ-025 SHALL, while reset=0, force out_valid=0, frame_done=0, window=all zero, col=row=0, FSM=FILL, and the 3x3 array to zero.
REQ-026 SHALL not reset line-buffer contents; they are not observable before being rewritten.
REQ-027 SHALL discard a partial frame on reset assertion mid-frame; the next accepted pixel is (0,0).

Configuration
REQ-028 SHALL, with CONV_STRIDE2_EN defined, emit windows only where (row-2) and (col-2) are both even, giving ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) windows per frame.
REQ-029 SHALL, without CONV_STRIDE2_EN, behave as stride 1 per REQ-017/REQ-023.

Structure
REQ-030 SHALL take regC, param9 and NBITS from packConv; the shared package SHALL gain constants IMG_W_DEF=32 and IMG_H_DEF=32.
REQ-031 SHALL instantiate sub-module line_buffer (parameter DEPTH, regC data, synchronous single-port read-before-write) twice.

Verification
REQ-032 SHALL be verified with IMG_W=IMG_H=4, pixels 0..15 and out_ready=1: 4 windows, the first {0,1,2,4,5,6,8,9,10} and the last {5,6,7,9,10,11,13,14,15}, with frame_done one cycle after pixel 15.
REQ-033 SHALL be verified for backpressure: out_ready=0 for 5 cycles after the first window -> window stable, in_ready=0, no pixel lost, then the remaining windows in order.
REQ-034 SHALL be verified with CONV_STRIDE2_EN, IMG_W=IMG_H=5 and pixels 0..24: exactly 4 windows, with top-left elements 0, 2, 10 and 12.
REQ-035 SHALL be verified with reset asserted after pixel 9 of a 4x4 frame, followed by a full frame 100..115: the first window is {100,101,102,104,105,106,108,109,110}.
REQ-036 SHALL be verified with two back-to-back 4x4 frames and in_valid held at 1: 8 windows total and two frame_done pulses, and no window mixes pixels from the two frames.
REQ-037 SHALL be verified with random in_valid/out_ready gaps on a 6x6 frame: 16 windows matching the golden model.
